// File: rtl/shift_mix_columns_if.sv
// Handshake bundle between the SubBytes FIFO, this stage and the AddRoundKey FIFO.
// Latency: none (wires only). Backpressure: carries the empty/full and rd/wr strobes.
// Ports: master = FIFO/environment side, slave = shift_mix_columns side.
interface shift_mix_columns_if;
    logic [127:0] in_state;
    logic         in_state_rd;
    logic         in_state_empty;
    logic [127:0] out_state;
    logic         out_state_wr;
    logic         out_state_full;
    logic         last_round;

    modport master (
        output in_state, in_state_empty, out_state_full,
        input  in_state_rd, out_state, out_state_wr, last_round
    );

    modport slave (
        input  in_state, in_state_empty, out_state_full,
        output in_state_rd, out_state, out_state_wr, last_round
    );
endinterface

// File: rtl/shift_mix_columns.sv
// AES ShiftRows + MixColumns round stage; the last round of each block bypasses MixColumns.
// Latency: 1 cycle pop-to-push (2 cycles when MIX_COLUMNS_PIPE_EN is defined), 1 state/cycle.
// Backpressure: pops only when the (first) register stage can accept; holds while downstream is full.
// Ports: clock, reset (sync, active-high); bus (slave modport) carries in_state/in_state_rd/
//        in_state_empty, out_state/out_state_wr/out_state_full and last_round.
// Optional macro MIX_COLUMNS_PIPE_EN: extra register between ShiftRows and MixColumns.
module shift_mix_columns #(
    parameter int NR    = 10,
    parameter int CNT_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    shift_mix_columns_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_RCNT = CNT_W'(NR - 1);

    // Byte k (k = 4c + r) lives at bits [(15-k)*8 +: 8].
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[(15 - (4 * c + r)) * 8 +: 8] = s[(15 - (4 * ((c + r) % 4) + r)) * 8 +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[(15 - 4 * c) * 8 +: 8];
            a1 = s[(14 - 4 * c) * 8 +: 8];
            a2 = s[(13 - 4 * c) * 8 +: 8];
            a3 = s[(12 - 4 * c) * 8 +: 8];
            // 3a = xtime(a) ^ a
            o[(15 - 4 * c) * 8 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[(14 - 4 * c) * 8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[(13 - 4 * c) * 8 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[(12 - 4 * c) * 8 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic [127:0]     out_reg;
    logic             out_valid;
    logic             out_last;
    logic [CNT_W-1:0] rcnt;

    logic             out_ready;
    logic             pop;
    logic             push;
    logic             is_last;

    assign out_ready = !out_valid || !bus.out_state_full;
    assign push      = !reset && out_valid && !bus.out_state_full;
    assign is_last   = (rcnt == LAST_RCNT);

    assign bus.in_state_rd  = pop;
    assign bus.out_state_wr = push;
    assign bus.out_state    = out_reg;
    assign bus.last_round   = out_last && push;

    // Round position of the state being popped; wraps at the end of each block.
    always_ff @(posedge clock) begin
        if (reset) begin
            rcnt <= '0;
        end else if (pop) begin
            rcnt <= is_last ? '0 : rcnt + 1'b1;
        end
    end

`ifdef MIX_COLUMNS_PIPE_EN
    logic [127:0] sr_reg;
    logic         sr_valid;
    logic         sr_last;
    logic         sr_ready;
    logic         load_out;

    // The first stage can take a new state when empty or when it moves on this cycle.
    assign load_out = sr_valid && out_ready;
    assign sr_ready = !sr_valid || out_ready;
    assign pop      = !reset && !bus.in_state_empty && sr_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            sr_reg   <= '0;
            sr_valid <= 1'b0;
            sr_last  <= 1'b0;
        end else if (pop) begin
            sr_reg   <= shift_rows(bus.in_state);
            sr_valid <= 1'b1;
            sr_last  <= is_last;
        end else if (load_out) begin
            sr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_reg   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load_out) begin
            out_reg   <= sr_last ? sr_reg : mix_columns(sr_reg);
            out_valid <= 1'b1;
            out_last  <= sr_last;
        end else if (push) begin
            out_valid <= 1'b0;
        end
    end
`else
    logic [127:0] shifted;

    assign pop     = !reset && !bus.in_state_empty && out_ready;
    assign shifted = shift_rows(bus.in_state);

    // A pop in the same cycle as a push reloads the register, keeping out_valid high.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_reg   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (pop) begin
            out_reg   <= is_last ? shifted : mix_columns(shifted);
            out_valid <= 1'b1;
            out_last  <= is_last;
        end else if (push) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_shift_mix_columns.sv
// Self-checking bench for shift_mix_columns: random states against a matrix-level AES model.
// Latency: checks 1 cycle (2 with MIX_COLUMNS_PIPE_EN). Backpressure: drives full/empty patterns.
// Ports: drives the master side of shift_mix_columns_if plus clock and reset.
module tb_shift_mix_columns;

    localparam int NR = 10;
`ifdef MIX_COLUMNS_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [127:0] R1_IN = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] R1_MC = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] R1_SR = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    typedef struct packed {
        logic [127:0] st;
        logic         last;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    shift_mix_columns_if bus();

    shift_mix_columns #(.NR(NR), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] src_q[$];
    exp_t         exp_q[$];
    exp_t         got_q[$];
    int           mrcnt;
    bit           force_empty;
    bit           hold_full;
    logic         s_rd, s_wr, s_last;
    logic [127:0] s_out;
    int           pops, pushes, cyc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // GF(2^8) multiply, shift-and-add with reduction by 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // One round stage on a 4x4 byte matrix: ShiftRows, then (unless bypassed) matrix multiply.
    function automatic logic [127:0] ref_round(input logic [127:0] s, input bit bypass);
        logic [7:0]   m[4][4];
        logic [7:0]   sh[4][4];
        logic [7:0]   o[4][4];
        logic [127:0] res;
        int           coef[4];
        coef = '{2, 3, 1, 1};
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[(15 - (4 * c + r)) * 8 +: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sh[r][c] = m[r][(c + r) % 4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (bypass) begin
                    o[r][c] = sh[r][c];
                end else begin
                    o[r][c] = 8'h00;
                    for (int i = 0; i < 4; i++)
                        o[r][c] = o[r][c] ^ gmul(8'(coef[(i - r + 4) % 4]), sh[i][c]);
                end
                res[(15 - (4 * c + r)) * 8 +: 8] = o[r][c];
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive();
        bus.in_state_empty = force_empty || (src_q.size() == 0);
        bus.in_state       = (src_q.size() > 0) ? src_q[0] : '0;
        bus.out_state_full = hold_full;
    endtask

    // One clock: sample at the falling edge, update the model, drive after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        cyc++;
        s_rd   = bus.in_state_rd;
        s_wr   = bus.out_state_wr;
        s_out  = bus.out_state;
        s_last = bus.last_round;
        if (!s_wr) check("last_without_push", s_last, 0);
        if (reset) begin
            check("rd_during_reset", s_rd, 0);
            check("wr_during_reset", s_wr, 0);
            exp_q.delete();
            mrcnt = 0;
        end else begin
            if (s_wr) begin
                pushes++;
                got_q.push_back({s_out, s_last});
                check("push_pending", 128'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data", s_out, e.st);
                    check("out_last", s_last, e.last);
                end
            end
            if (force_empty || src_q.size() == 0) begin
                check("rd_while_empty", s_rd, 0);
            end else if (s_rd) begin
                pops++;
                e.last = (mrcnt == NR - 1);
                e.st   = ref_round(src_q[0], e.last);
                exp_q.push_back(e);
                void'(src_q.pop_front());
                mrcnt = (mrcnt + 1) % NR;
            end
        end
        @(posedge clock);
        #1;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && (exp_q.size() > 0 || src_q.size() > 0); i++) tick();
        check(tag, 128'(exp_q.size() + src_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t_pop, t_push, n, first_rd, last_rd, first_wr, last_wr;
        reset = 1'b1;
        force_empty = 1'b0;
        hold_full = 1'b0;
        mrcnt = 0;
        cyc = 0;
        drive();
        tick();
        tick();
        reset = 1'b0;

        // Reset state with an empty upstream.
        tick();
        check("rst_out_state", s_out, 0);
        check("rst_wr", s_wr, 0);
        check("rst_rd", s_rd, 0);
        check("rst_last", s_last, 0);

        // Round 1 vector and latency.
        src_q.push_back(R1_IN);
        drive();
        t_pop = -1;
        t_push = -1;
        for (int i = 0; i < 10 && t_push < 0; i++) begin
            tick();
            if (s_rd && t_pop < 0) t_pop = cyc;
            if (s_wr) begin
                t_push = cyc;
                check("r1_data", s_out, R1_MC);
                check("r1_last", s_last, 0);
            end
        end
        check("r1_latency", t_push - t_pop, LAT);

        // Final-round bypass and wrap back to round 0.
        do_reset();
        for (int i = 0; i < 9; i++) src_q.push_back(rnd_state());
        src_q.push_back(R1_IN);
        src_q.push_back(R1_IN);
        drive();
        got_q.delete();
        for (int i = 0; i < 40 && got_q.size() < 11; i++) tick();
        check("fin_count", got_q.size(), 11);
        if (got_q.size() >= 11) begin
            check("fin_bypass_data", got_q[9].st, R1_SR);
            check("fin_bypass_last", got_q[9].last, 1);
            check("wrap_data", got_q[10].st, R1_MC);
            check("wrap_last", got_q[10].last, 0);
        end

        // Backpressure: downstream full for 5 cycles.
        hold_full = 1'b1;
        for (int i = 0; i < 8; i++) src_q.push_back(rnd_state());
        drive();
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_no_push", s_wr, 0);
        end
        check("bp_pops", pops, LAT);
        if (exp_q.size() > 0) check("bp_hold", bus.out_state, exp_q[0].st);
        hold_full = 1'b0;
        drive();
        pushes = 0;
        n = 0;
        for (int i = 0; i < 40 && pushes < 8; i++) begin
            tick();
            n++;
        end
        check("bp_release_cycles", n, 8);
        check("bp_release_pushes", pushes, 8);

        // Streaming 20 back-to-back states.
        for (int i = 0; i < 20; i++) src_q.push_back(rnd_state());
        drive();
        pops = 0;
        pushes = 0;
        first_rd = -1; last_rd = -1; first_wr = -1; last_wr = -1;
        for (int i = 0; i < 60 && pushes < 20; i++) begin
            tick();
            if (s_rd) begin
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (s_wr) begin
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
        end
        check("stream_pops", pops, 20);
        check("stream_rd_run", last_rd - first_rd + 1, 20);
        check("stream_wr_run", last_wr - first_wr + 1, 20);
        check("stream_latency", first_wr - first_rd, LAT);

        // Reset mid-stream with rcnt = 5 and a pending output.
        do_reset();
        for (int i = 0; i < 7; i++) src_q.push_back(rnd_state());
        drive();
        pops = 0;
        for (int i = 0; i < 20 && pops < 5; i++) tick();
        check("mid_pops", pops, 5);
        force_empty = 1'b1;
        hold_full = 1'b1;
        drive();
        tick();
        check("mid_pending_hold", s_wr, 0);
        force_empty = 1'b0;
        hold_full = 1'b0;
        drive();
        do_reset();
        force_empty = 1'b1;
        drive();
        tick();
        check("mid_rst_out", s_out, 0);
        check("mid_rst_wr", s_wr, 0);
        src_q.delete();
        src_q.push_back(R1_IN);
        force_empty = 1'b0;
        drive();
        got_q.delete();
        for (int i = 0; i < 10 && got_q.size() < 1; i++) tick();
        check("mid_r0_count", got_q.size(), 1);
        if (got_q.size() > 0) check("mid_r0_data", got_q[0].st, R1_MC);

        // Empty upstream: no pops, pending output drains exactly once.
        hold_full = 1'b1;
        src_q.push_back(rnd_state());
        drive();
        pops = 0;
        for (int i = 0; i < 4; i++) tick();
        check("empty_prefill", pops, 1);
        force_empty = 1'b1;
        src_q.push_back(rnd_state());
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty_no_rd", s_rd, 0);
        end
        hold_full = 1'b0;
        drive();
        pushes = 0;
        for (int i = 0; i < 5; i++) tick();
        check("empty_drain_once", pushes, 1);
        force_empty = 1'b0;
        drive();
        drain("empty_resume", 20);

        // Random full/empty traffic across several block boundaries.
        for (int i = 0; i < 60; i++) src_q.push_back(rnd_state());
        drive();
        for (int i = 0; i < 500 && (src_q.size() > 0 || exp_q.size() > 0); i++) begin
            force_empty = ($urandom_range(0, 3) == 0);
            hold_full = ($urandom_range(0, 3) == 0);
            drive();
            tick();
        end
        force_empty = 1'b0;
        hold_full = 1'b0;
        drive();
        drain("random_drain", 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
